alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID→EX issue stage sitting directly upstream of the ALU; it feeds `first_operand`, `second_operand` and `ALU_Control`.
- Decodes main-control ALUOp plus the R-type funct field into the 4-bit ALU control code.
- Selects the second operand (register or sign-extended immediate) and registers the bundle behind a valid/ready handshake.
- Uses a 2-entry skid buffer so `in_ready` is a pure register output, with flush support for branch redirect.

Parameters:
- XLEN, 32, datapath width of operands.
- RADDR_W, 5, destination register address width.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode has an instruction bundle
- in_ready  out  1  stage can accept; registered
- alu_op  in  2  main-control ALUOp
- funct  in  6  instruction[5:0]
- alu_src  in  1  1 = immediate as second operand
- rs_data  in  XLEN  register-file read port A
- rt_data  in  XLEN  register-file read port B
- imm16  in  16  instruction[15:0]
- rd_addr  in  RADDR_W  destination register, carried through
- flush  in  1  kill all held and incoming bundles this cycle
- out_valid  out  1  bundle presented to ALU
- out_ready  in  1  EX stage consumes bundle
- first_operand  out  XLEN  to ALU
- second_operand  out  XLEN  to ALU
- alu_control  out  4  to ALU
- out_rd_addr  out  RADDR_W  carried destination

Behaviour:
- **Decode (combinational on input side)**
  - ALUOp 00 → 0010 (add, lw/sw).
  - ALUOp 01 → 0110 (sub, beq).
  - ALUOp 11 → 0010 (addi).
  - ALUOp 10 → by funct: 100000 → 0010, 100010 → 0110, 100100 → 0000, 100101 → 0001, 101010 → 0111, 100111 → 1100; any other funct → 0010 and the bundle is marked illegal.
- **Second operand:** alu_src=1 → imm16 sign-extended to XLEN ({16{imm16[15]}}, imm16); otherwise rt_data. first_operand = rs_data.
- **Storage:** main register M (drives outputs) and skid register S, each with a valid bit.
- **States:** EMPTY (M and S invalid), ONE (M valid), FULL (M and S valid).
- **Accept:** an input is accepted when in_valid && in_ready.
- **in_ready:** registered, equals !S.valid for the next cycle. Deasserts only in FULL.
- **Transitions:**
  - EMPTY + accept → ONE.
  - ONE + accept without consume → FULL; new bundle goes to S.
  - ONE + accept + consume → ONE; M reloaded.
  - ONE + consume without accept → EMPTY.
  - FULL + consume → ONE; S moves to M. No accept is possible in FULL.
- **Ordering:** bundles leave strictly in acceptance order.
- **Latency:** 1 cycle from accept to out_valid when EMPTY. Throughput is 1/cycle with out_ready held high.
- **Output stability:** while out_valid && !out_ready, all outputs hold stable.
- **flush:** has priority over every other event. At the next edge M.valid=0 and S.valid=0, and the same-cycle input is discarded even if in_valid && in_ready. in_ready=1 the following cycle.
- **Reset (async, rst_n=0):** out_valid=0, in_ready=0 while asserted, in_ready=1 on the first edge after release. Operands, alu_control and out_rd_addr reset to 0.
- **Reset mid-operation:** all held bundles are dropped; no partial bundle is emitted after release.
- **out_valid=0 consumer rule:** out_ready is ignored, and the EX stage must ignore the data outputs.

Optional Feature:
- Macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
- **With the macro defined:**
  - Adds output `illegal_op` (1 bit), asserted alongside out_valid when the presented bundle carried an unknown ALUOp=10 funct.
  - Adds output `illegal_seen` (1 bit), sticky, set on the first such bundle consumed and cleared only by rst_n.
  - Operands and alu_control are unchanged (0010).
- **Without the macro:** neither port exists; an illegal funct silently decodes to add.

Decomposition:
- **Shared package `alu_pkg`:**
  - 4-bit ALU control localparams: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100.
  - ALUOp encodings.
  - funct constants.
  - Issue-bundle struct: op1, op2, ctrl, rd, illegal.
- **Sub-module `alu_ctrl_decode`:** combinational ALUOp/funct → ctrl + illegal. It is reused by the single-cycle datapath. The skid logic stays in the top module.

Test Plan:
- **Reset and R-type decode:** reset, then one R-type and (ALUOp=10, funct=100100, rs=0xF0F0_0000, rt=0x0FF0_0000) with out_ready=1 → next cycle out_valid=1, alu_control=0000, first_operand=0xF0F0_0000, second_operand=0x0FF0_0000.
- **Immediate sign-extend:** ALUOp=11, alu_src=1, imm16=0xFFFC, rs=0x10 → second_operand=0xFFFF_FFFC, alu_control=0010.
- **Backpressure:** out_ready=0, issue bundles A (funct 100010) then B (funct 101010) on consecutive cycles → in_ready drops the cycle after B is accepted and A holds stable (ctrl 0110). Raise out_ready → A, then B (ctrl 0111) on consecutive cycles, then in_ready=1.
- **Flush while FULL:** flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- **Illegal funct:** ALUOp=10, funct=000000 → alu_control=0010. With ALU_ISSUE_ILLEGAL_TRAP_EN, illegal_op=1 with the bundle and illegal_seen=1 after it is consumed.
- **Streaming and mid-stream reset:** 100 back-to-back random bundles with random out_ready, checked against a scoreboard for order and values. Then assert rst_n low mid-stream → out_valid=0 immediately (async).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings: control codes, ALUOp values, R-type funct values and the issue bundle.
// Also used by the single-cycle datapath, so keep encodings stable.
package alu_pkg;

   localparam int ISSUE_XLEN    = 32;
   localparam int ISSUE_RADDR_W = 5;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_IMM    = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_NOR = 6'b100111;

   typedef struct packed {
      logic [ISSUE_XLEN-1:0]    op1;
      logic [ISSUE_XLEN-1:0]    op2;
      logic [3:0]               ctrl;
      logic [ISSUE_RADDR_W-1:0] rd;
      logic                     illegal;
   } issue_bundle_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side and ALU-side handshake bundle of the issue stage; master = environment, slave = stage.
// Illegal-op trap signals exist only with ALU_ISSUE_ILLEGAL_TRAP_EN.
interface alu_issue_stage_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         alu_op;
   logic [5:0]         funct;
   logic               alu_src;
   logic [XLEN-1:0]    rs_data;
   logic [XLEN-1:0]    rt_data;
   logic [15:0]        imm16;
   logic [RADDR_W-1:0] rd_addr;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    first_operand;
   logic [XLEN-1:0]    second_operand;
   logic [3:0]         alu_control;
   logic [RADDR_W-1:0] out_rd_addr;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   logic               illegal_op;
   logic               illegal_seen;
`endif

   modport master (
      output in_valid, alu_op, funct, alu_src, rs_data, rt_data, imm16, rd_addr, flush, out_ready,
      input  in_ready, out_valid, first_operand, second_operand, alu_control, out_rd_addr
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      , input illegal_op, illegal_seen
`endif
   );

   modport slave (
      input  in_valid, alu_op, funct, alu_src, rs_data, rt_data, imm16, rd_addr, flush, out_ready,
      output in_ready, out_valid, first_operand, second_operand, alu_control, out_rd_addr
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      , output illegal_op, illegal_seen
`endif
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// ALUOp + funct to 4-bit ALU control; purely combinational, no handshake.
// Unknown R-type funct falls back to add and raises illegal.
module alu_ctrl_decode
   import alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] ctrl,
   output logic       illegal
);

   always_comb begin
      ctrl    = ALU_ADD;
      illegal = 1'b0;
      case (alu_op)
         ALUOP_MEM:    ctrl = ALU_ADD;
         ALUOP_BRANCH: ctrl = ALU_SUB;
         ALUOP_IMM:    ctrl = ALU_ADD;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: ctrl = ALU_ADD;
               FUNCT_SUB: ctrl = ALU_SUB;
               FUNCT_AND: ctrl = ALU_AND;
               FUNCT_OR:  ctrl = ALU_OR;
               FUNCT_SLT: ctrl = ALU_SLT;
               FUNCT_NOR: ctrl = ALU_NOR;
               default: begin
                  ctrl    = ALU_ADD;
                  illegal = 1'b1;
               end
            endcase
         end
         default: ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode, operand select, 2-entry skid buffer; 1 cycle accept->out_valid.
// in_ready is registered and drops only when both entries are held; flush clears everything.
// Optional illegal-funct reporting under ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN    = ISSUE_XLEN,
   parameter int RADDR_W = ISSUE_RADDR_W
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_issue_stage_if.slave bus
);

   typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

   state_t             state;
   issue_bundle_t      m_q;
   issue_bundle_t      s_q;
   issue_bundle_t      in_b;
   logic               out_valid_q;
   logic               in_ready_q;
   logic [3:0]         dec_ctrl;
   logic               dec_illegal;
   logic [XLEN-1:0]    op2_in;
   logic [RADDR_W-1:0] rd_in;
   logic               accept;
   logic               consume;

   alu_ctrl_decode u_dec (
      .alu_op  (bus.alu_op),
      .funct   (bus.funct),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   assign op2_in = bus.alu_src ? {{(XLEN-16){bus.imm16[15]}}, bus.imm16} : bus.rt_data;
   assign rd_in  = bus.rd_addr;

   always_comb begin
      in_b         = '0;
      in_b.op1     = bus.rs_data;
      in_b.op2     = op2_in;
      in_b.ctrl    = dec_ctrl;
      in_b.rd      = rd_in;
      in_b.illegal = dec_illegal;
   end

   assign accept  = bus.in_valid && in_ready_q;
   assign consume = out_valid_q && bus.out_ready;

   // M always feeds the outputs; S only holds the bundle that arrived while M was stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_EMPTY;
         m_q         <= '0;
         s_q         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else if (bus.flush) begin
         state       <= ST_EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  m_q         <= in_b;
                  out_valid_q <= 1'b1;
                  state       <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !consume) begin
                  s_q        <= in_b;
                  in_ready_q <= 1'b0;
                  state      <= ST_FULL;
               end else if (accept && consume) begin
                  m_q <= in_b;
               end else if (consume) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (consume) begin
                  m_q        <= s_q;
                  in_ready_q <= 1'b1;
                  state      <= ST_ONE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= ST_EMPTY;
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.first_operand  = m_q.op1;
   assign bus.second_operand = m_q.op2;
   assign bus.alu_control    = m_q.ctrl;
   assign bus.out_rd_addr    = m_q.rd;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   logic illegal_seen_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_seen_q <= 1'b0;
      end else if (consume && m_q.illegal && !bus.flush) begin
         illegal_seen_q <= 1'b1;
      end
   end

   assign bus.illegal_op   = out_valid_q && m_q.illegal;
   assign bus.illegal_seen = illegal_seen_q;
`else
   logic illegal_unused;
   assign illegal_unused = m_q.illegal;
`endif

endmodule
